// File: rtl/led_pattern_pkg.sv
// Shared types and default sizing for the status-LED pattern bank.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'b00,
        ON        = 2'b01,
        BLINK     = 2'b10,
        HEARTBEAT = 2'b11
    } led_mode_t;

    typedef enum logic [1:0] {
        ON1   = 2'b00,
        OFF1  = 2'b01,
        ON2   = 2'b10,
        PAUSE = 2'b11
    } hb_state_t;

    localparam int DEF_PER_W      = 10;
    localparam int DEF_PAUSE_MULT = 5;

endpackage

// File: rtl/led_pattern_chan.sv
// One LED channel: mode latch, phase FSM, phase counter and period latch.
// Advances only on the shared tick; sync and mode changes restart the pattern.
module led_pattern_chan
    import led_pattern_pkg::*;
#(
    parameter int PER_W      = DEF_PER_W,
    parameter int PAUSE_MULT = DEF_PAUSE_MULT
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             tick_i,
    input  logic             sync_i,
    input  led_mode_t        mode_i,
    input  logic [PER_W-1:0] period_i,
    output logic             led_o
);

    // Wide enough for PAUSE_MULT * max period without overflow.
    localparam int CNT_W = PER_W + $clog2(PAUSE_MULT + 1);

    led_mode_t        mode_q,   mode_d;
    hb_state_t        state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             led_q,    led_d;

    logic [PER_W-1:0] periodEff;
    logic [CNT_W-1:0] phaseLen;
    logic             phaseDone;

    always_comb begin
        periodEff = (period_i == '0) ? PER_W'(1) : period_i;
        phaseLen  = (state_q == PAUSE) ? CNT_W'(period_q) * CNT_W'(PAUSE_MULT)
                                       : CNT_W'(period_q);
        phaseDone = (cnt_q == phaseLen - CNT_W'(1));
    end

    always_comb begin
        mode_d   = mode_i;
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        led_d    = 1'b0;

        // Restart (sync or mode change) outranks any coincident tick.
        if (sync_i || (mode_i != mode_q)) begin
            state_d  = ON1;
            cnt_d    = '0;
            period_d = periodEff;
        end else if ((mode_q == OFF) || (mode_q == ON)) begin
            state_d  = ON1;
            cnt_d    = '0;
        end else if (tick_i) begin
            if (phaseDone) begin
                cnt_d    = '0;
                period_d = periodEff;
                if (mode_q == BLINK) begin
                    state_d = (state_q == ON1) ? OFF1 : ON1;
                end else begin
                    case (state_q)
                        ON1:     state_d = OFF1;
                        OFF1:    state_d = ON2;
                        ON2:     state_d = PAUSE;
                        default: state_d = ON1;
                    endcase
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (mode_d)
            ON:        led_d = 1'b1;
            BLINK:     led_d = (state_d == ON1);
            HEARTBEAT: led_d = (state_d == ON1) || (state_d == ON2);
            default:   led_d = 1'b0;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q   <= OFF;
            state_q  <= ON1;
            cnt_q    <= '0;
            period_q <= PER_W'(1);
            led_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            led_q    <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_pattern_bank.sv
// NCHAN independent LED pattern channels sharing one tick prescaler.
// The registered tick strobe is also what the channels advance on.
module led_pattern_bank
    import led_pattern_pkg::*;
#(
    parameter int NCHAN      = 4,
    parameter int TICK_DIV   = 100000,
    parameter int PER_W      = DEF_PER_W,
    parameter int PAUSE_MULT = DEF_PAUSE_MULT
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [2*NCHAN-1:0]       mode_i,
    input  logic [NCHAN*PER_W-1:0]   period_i,
    input  logic                     sync_i,
    output logic [NCHAN-1:0]         led_o,
    output logic                     tick_o
);

    localparam int              PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] presc_q, presc_d;
    logic            tick_q,  tick_d;

    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (sync_i) begin
            presc_d = '0;
        end else if (presc_q == PS_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
        end else begin
            presc_d = presc_q + PS_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_o = tick_q;

    for (genvar k = 0; k < NCHAN; k++) begin : g_chan
        led_pattern_chan #(
            .PER_W      (PER_W),
            .PAUSE_MULT (PAUSE_MULT)
        ) u_chan (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .tick_i    (tick_q),
            .sync_i    (sync_i),
            .mode_i    (led_mode_t'(mode_i[2*k +: 2])),
            .period_i  (period_i[k*PER_W +: PER_W]),
            .led_o     (led_o[k])
        );
    end

endmodule

// File: tb/tb_led_pattern_bank.sv
// Directed self-checking bench for led_pattern_bank with TICK_DIV=4.
// Samples on the falling edge; expected LED levels come from tick-count formulas.
module tb_led_pattern_bank;

    localparam int NCHAN      = 4;
    localparam int TICK_DIV   = 4;
    localparam int PER_W      = 10;
    localparam int PAUSE_MULT = 5;

    logic                   sysClk;
    logic                   sysRstN;
    logic [2*NCHAN-1:0]     modeIn;
    logic [NCHAN*PER_W-1:0] periodIn;
    logic                   syncIn;
    logic [NCHAN-1:0]       ledOut;
    logic                   tickOut;

    int checkCount;
    int errorCount;

    led_pattern_bank #(
        .NCHAN      (NCHAN),
        .TICK_DIV   (TICK_DIV),
        .PER_W      (PER_W),
        .PAUSE_MULT (PAUSE_MULT)
    ) dut (
        .sys_clk   (sysClk),
        .sys_rst_n (sysRstN),
        .mode_i    (modeIn),
        .period_i  (periodIn),
        .sync_i    (syncIn),
        .led_o     (ledOut),
        .tick_o    (tickOut)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    task automatic applyStimulus(input logic [2*NCHAN-1:0] mode,
                                 input logic [NCHAN*PER_W-1:0] period,
                                 input logic sync);
        modeIn   = mode;
        periodIn = period;
        syncIn   = sync;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic blinkLed(input int t, input int p);
        return ((t / p) % 2) == 0;
    endfunction

    function automatic logic hbLed(input int t, input int p);
        int pos;
        pos = t % ((3 + PAUSE_MULT) * p);
        return (pos < p) || ((pos >= 2 * p) && (pos < 3 * p));
    endfunction

    initial begin
        logic [2*NCHAN-1:0]     mode;
        logic [NCHAN*PER_W-1:0] period;
        logic [3:0]             expLed;
        int                     t;

        checkCount = 0;
        errorCount = 0;

        // ch3 ON, ch2 BLINK P=0, ch1 HEARTBEAT P=1, ch0 BLINK P=2
        mode   = 8'b01_10_11_10;
        period = '0;
        period[0*PER_W +: PER_W] = 10'd2;
        period[1*PER_W +: PER_W] = 10'd1;
        period[2*PER_W +: PER_W] = 10'd0;
        period[3*PER_W +: PER_W] = 10'd2;
        sysRstN = 1'b0;
        applyStimulus(mode, period, 1'b0);
        repeat (3) @(negedge sysClk);
        checkOutput("reset_led", ledOut, 4'h0);
        checkOutput("reset_tick", {3'b0, tickOut}, 4'h0);
        $display("[TB] releasing reset");
        sysRstN = 1'b1;

        for (int k = 1; k <= 83; k++) begin
            @(negedge sysClk);
            t = (k - 1) / 4;
            expLed[0] = blinkLed(t, 2);
            expLed[1] = hbLed(t, 1);
            if (k <= 44)      expLed[2] = blinkLed(t, 1);
            else if (k <= 56) expLed[2] = 1'b0;
            else              expLed[2] = (((k - 57) / 12) % 2) == 0;
            if (k <= 60)      expLed[3] = 1'b1;
            else if (k <= 63) expLed[3] = 1'b0;
            else if (k <= 68) expLed[3] = 1'b1;
            else              expLed[3] = (((k - 69) / 8) % 2) == 1;
            checkOutput("run_tick", {3'b0, tickOut}, {3'b0, (k % 4) == 0});
            checkOutput("run_led", ledOut, expLed);
            if (k == 41) period[2*PER_W +: PER_W] = 10'd3;
            if (k == 60) mode[7:6] = 2'b00;
            if (k == 63) mode[7:6] = 2'b10;
            applyStimulus(mode, period, k == 83);
        end

        // sync landed in the cycle before a tick: tick suppressed, all at ON1
        for (int k = 84; k <= 104; k++) begin
            @(negedge sysClk);
            t = (k >= 85) ? (k - 85) / 4 : 0;
            expLed[0] = blinkLed(t, 2);
            expLed[1] = hbLed(t, 1);
            expLed[2] = blinkLed(t, 3);
            expLed[3] = blinkLed(t, 2);
            checkOutput("sync_tick", {3'b0, tickOut}, {3'b0, ((k % 4) == 0) && (k != 84)});
            checkOutput("sync_led", ledOut, expLed);
            applyStimulus(mode, period, 1'b0);
        end

        // ch1 is mid-PAUSE and tick_o is high; reset between edges
        #2;
        sysRstN = 1'b0;
        #1;
        checkOutput("async_led", ledOut, 4'h0);
        checkOutput("async_tick", {3'b0, tickOut}, 4'h0);
        mode = '0;
        applyStimulus(mode, period, 1'b0);
        repeat (2) @(negedge sysClk);
        checkOutput("held_led", ledOut, 4'h0);
        sysRstN = 1'b1;

        for (int k = 1; k <= 16; k++) begin
            @(negedge sysClk);
            expLed = (k >= 9) ? 4'b0001 : 4'b0000;
            if (k <= 11)
                checkOutput("post_tick", {3'b0, tickOut}, {3'b0, (k % 4) == 0});
            else
                checkOutput("resync_tick", {3'b0, tickOut}, {3'b0, k == 15});
            checkOutput("post_led", ledOut, expLed);
            if (k == 8) mode[1:0] = 2'b01;
            applyStimulus(mode, period, k == 10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
